// File: rtl/cdc_wrptr_full_level.sv
// Write-domain pointer, fill level and full/almost-full flags for the dual-clock FIFO.
// Optional sticky overflow flag with its clear input, enabled by CDC_WRPTR_OVFL_EN.
module cdc_wrptr_full_level #(
    parameter int unsigned ADDRSIZE     = 4,
    parameter int unsigned AFULL_THRESH = 2**ADDRSIZE - 2
) (
    input  logic                wr_clk,
    input  logic                wr_rst,
    input  logic [ADDRSIZE:0]   wrq2_rdptr,
    input  logic                wr_inc,
`ifdef CDC_WRPTR_OVFL_EN
    input  logic                wr_ovf_clr,
`endif
    output logic [ADDRSIZE-1:0] wr_addr,
    output logic [ADDRSIZE:0]   wr_ptr,
    output logic                wr_full,
    output logic                wr_afull,
    output logic [ADDRSIZE:0]   wr_level
`ifdef CDC_WRPTR_OVFL_EN
    ,
    output logic                wr_overflow
`endif
);

    localparam logic [ADDRSIZE:0] FullLvl  = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0] AfullLvl = AFULL_THRESH[ADDRSIZE:0];

    logic [ADDRSIZE:0] wbin_q;
    logic [ADDRSIZE:0] wbin_d;
    logic [ADDRSIZE:0] wgray_d;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] lvl_d;
    logic              wr_we;

    assign wr_we   = wr_inc & ~wr_full;
    assign wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, wr_we};
    assign wgray_d = (wbin_d >> 1) ^ wbin_d;
    assign wr_addr = wbin_q[ADDRSIZE-1:0];

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= int'(ADDRSIZE); i++) begin
            rbin[i] = ^(wrq2_rdptr >> i);
        end
    end

    assign lvl_d = wbin_d - rbin;

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wbin_q   <= '0;
            wr_ptr   <= '0;
            wr_level <= '0;
            wr_full  <= 1'b0;
            wr_afull <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wr_ptr   <= wgray_d;
            wr_level <= lvl_d;
            wr_full  <= (lvl_d == FullLvl);
            wr_afull <= (lvl_d >= AfullLvl);
        end
    end

`ifdef CDC_WRPTR_OVFL_EN
    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wr_overflow <= 1'b0;
        end else if (wr_inc & wr_full) begin
            wr_overflow <= 1'b1;
        end else if (wr_ovf_clr) begin
            wr_overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_cdc_wrptr_full_level.sv
// Randomized self-checking bench for cdc_wrptr_full_level (ADDRSIZE=2, AFULL_THRESH=3).
// Expected values come from an occupancy model counting writes and reads.
module tb_cdc_wrptr_full_level;

    logic       wr_clk;
    logic       wr_rst;
    logic [2:0] wrq2_rdptr;
    logic       wr_inc;
    logic [1:0] wr_addr;
    logic [2:0] wr_ptr;
    logic       wr_full;
    logic       wr_afull;
    logic [2:0] wr_level;
`ifdef CDC_WRPTR_OVFL_EN
    logic       wr_ovf_clr;
    logic       wr_overflow;
`endif

    cdc_wrptr_full_level #(
        .ADDRSIZE    (2),
        .AFULL_THRESH(3)
    ) dut (
        .wr_clk     (wr_clk),
        .wr_rst     (wr_rst),
        .wrq2_rdptr (wrq2_rdptr),
        .wr_inc     (wr_inc),
`ifdef CDC_WRPTR_OVFL_EN
        .wr_ovf_clr (wr_ovf_clr),
`endif
        .wr_addr    (wr_addr),
        .wr_ptr     (wr_ptr),
        .wr_full    (wr_full),
        .wr_afull   (wr_afull),
        .wr_level   (wr_level)
`ifdef CDC_WRPTR_OVFL_EN
        ,
        .wr_overflow(wr_overflow)
`endif
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int   n_checks = 0;
    int   n_errors = 0;

    // Model: total writes accepted and reads performed, modulo 8.
    int   m_wcnt;
    int   m_rcnt;
    int   m_lvl;
    logic m_ovf;
    logic [2:0] last_rdg;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] to_gray(input int b);
        logic [2:0] v;
        v = 3'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic int from_gray(input logic [2:0] g);
        for (int b = 0; b < 8; b++) begin
            if (to_gray(b) == g) return b;
        end
        return 0;
    endfunction

    task automatic check_all();
        check_eq("addr", 32'(wr_addr), 32'(m_wcnt % 4));
        check_eq("ptr", 32'(wr_ptr), 32'(to_gray(m_wcnt)));
        check_eq("level", 32'(wr_level), 32'(m_lvl));
        check_eq("full", 32'(wr_full), 32'(m_lvl == 4));
        check_eq("afull", 32'(wr_afull), 32'(m_lvl >= 3));
        check_eq("full_gray", 32'(wr_full),
                 32'(wr_ptr == {~last_rdg[2:1], last_rdg[0]}));
`ifdef CDC_WRPTR_OVFL_EN
        check_eq("overflow", 32'(wr_overflow), 32'(m_ovf));
`endif
    endtask

    task automatic step(input logic inc, input logic [2:0] rdg, input logic clr);
        logic was_full;
        @(negedge wr_clk);
        wr_inc     = inc;
        wrq2_rdptr = rdg;
`ifdef CDC_WRPTR_OVFL_EN
        wr_ovf_clr = clr;
`endif
        #1 check_eq("addr_pre", 32'(wr_addr), 32'(m_wcnt % 4));
        @(posedge wr_clk);
        was_full = (m_lvl == 4);
        if (inc && !was_full) m_wcnt = (m_wcnt + 1) % 8;
        m_rcnt   = from_gray(rdg);
        m_lvl    = (m_wcnt - m_rcnt + 8) % 8;
        if (inc && was_full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        last_rdg = rdg;
        #1 check_all();
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        wr_rst     = 1'b1;
        wr_inc     = 1'b1;
        wrq2_rdptr = 3'd0;
`ifdef CDC_WRPTR_OVFL_EN
        wr_ovf_clr = 1'b0;
`endif
        m_wcnt   = 0;
        m_rcnt   = 0;
        m_lvl    = 0;
        m_ovf    = 1'b0;
        last_rdg = 3'd0;
        repeat (2) begin
            @(posedge wr_clk);
            #1 check_all();
        end
        @(negedge wr_clk);
        wr_rst = 1'b0;
        wr_inc = 1'b0;
    endtask

    initial begin
        int exp_ptr[4];
        logic wrap_seen;
        logic [2:0] prev_ptr;
        logic full_seen;
        int adv;

        exp_ptr = '{1, 3, 2, 6};
        wr_rst = 1'b1;
        wr_inc = 1'b0;
        wrq2_rdptr = 3'd0;
`ifdef CDC_WRPTR_OVFL_EN
        wr_ovf_clr = 1'b0;
`endif
        do_reset();

        // Fill to full with the reader idle.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'd0, 1'b0);
            check_eq("fill_ptr", 32'(wr_ptr), 32'(exp_ptr[i]));
            check_eq("fill_level", 32'(wr_level), 32'(i + 1));
        end

        // Dropped write while full, then clear the sticky flag.
        step(1'b1, 3'd0, 1'b0);
        check_eq("ovf_ptr", 32'(wr_ptr), 32'd6);
        check_eq("ovf_addr", 32'(wr_addr), 32'd0);
        step(1'b1, 3'd0, 1'b1);
        step(1'b0, 3'd0, 1'b1);

        // Reader consumes two entries.
        step(1'b0, 3'd3, 1'b0);
        check_eq("drain_level", 32'(wr_level), 32'd2);
        check_eq("drain_full", 32'(wr_full), 32'd0);
        check_eq("drain_afull", 32'(wr_afull), 32'd0);

        // Write plus read in the same cycle at level 3.
        step(1'b1, 3'd3, 1'b0);
        check_eq("sim_pre_level", 32'(wr_level), 32'd3);
        step(1'b1, to_gray(3), 1'b0);
        check_eq("sim_level", 32'(wr_level), 32'd3);
        check_eq("sim_ptr", 32'(wr_ptr), 32'd5);

        // Reader trails by two through a pointer wrap.
        step(1'b0, to_gray(m_wcnt - 2 + 8), 1'b0);
        wrap_seen = 1'b0;
        full_seen = 1'b0;
        prev_ptr  = wr_ptr;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, to_gray(m_wcnt - 1 + 8), 1'b0);
            check_eq("wrap_level", 32'(wr_level), 32'd2);
            if (prev_ptr == 3'd4 && wr_ptr == 3'd0) wrap_seen = 1'b1;
            if (wr_full) full_seen = 1'b1;
            prev_ptr = wr_ptr;
        end
        check_eq("wrap_seen", 32'(wrap_seen), 32'd1);
        check_eq("wrap_no_full", 32'(full_seen), 32'd0);

        // Reset in the middle of traffic, then random traffic.
        step(1'b1, last_rdg, 1'b0);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            adv = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, m_lvl)) : 0;
            step(1'($urandom_range(0, 3) != 0), to_gray(m_rcnt + adv),
                 1'($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
